// File: rtl/precision_game_core.sv
// Reaction game: a lit LED sweeps the 16-position playfield at the MODE rate and the player
// presses BTN to stop it on TARGET. It keeps the total score and the current hit streak.
module precision_game_core #(
    parameter int unsigned TARGET     = 8,
    parameter int unsigned HOLD_TICKS = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MODE,
    input  logic        BTN,
    output logic [15:0] LED,
    output logic [1:0]  STATE,
    output logic [7:0]  SCORE,
    output logic [3:0]  STREAK,
    output logic        WIN,
    output logic        LOSE
);

    localparam int unsigned TW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [3:0]    TGT       = 4'(TARGET);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHit  = 2'b10,
        StMiss = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    pos_q, pos_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0]    score_q, score_d;
    logic [3:0]    streak_q, streak_d;
    logic          win_q, win_d;
    logic          lose_q, lose_d;

    logic mode_meta_q, mode_sync_q, mode_prev_q;
    logic btn_meta_q, btn_sync_q, btn_prev_q;
    logic step, press;

    // Two-flop synchronizers plus a delayed copy that is used for rising-edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_meta_q <= 1'b0;
            mode_sync_q <= 1'b0;
            mode_prev_q <= 1'b0;
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
            btn_prev_q  <= 1'b0;
        end else begin
            mode_meta_q <= MODE;
            mode_sync_q <= mode_meta_q;
            mode_prev_q <= mode_sync_q;
            btn_meta_q  <= BTN;
            btn_sync_q  <= btn_meta_q;
            btn_prev_q  <= btn_sync_q;
        end
    end

    assign step  = mode_sync_q & ~mode_prev_q;
    assign press = btn_sync_q & ~btn_prev_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            pos_q    <= 4'd0;
            tmr_q    <= '0;
            score_q  <= 8'd0;
            streak_q <= 4'd0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            tmr_q    <= tmr_d;
            score_q  <= score_d;
            streak_q <= streak_d;
            win_q    <= win_d;
            lose_q   <= lose_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        tmr_d    = tmr_q;
        score_d  = score_q;
        streak_d = streak_q;
        win_d    = 1'b0;
        lose_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (press) begin
                    pos_d   = 4'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // A press takes priority over a coincident step, so the position is judged
                // before it would have advanced.
                if (press) begin
                    tmr_d = '0;
                    if (pos_q == TGT) begin
                        state_d  = StHit;
                        win_d    = 1'b1;
                        score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
                    end else begin
                        state_d  = StMiss;
                        lose_d   = 1'b1;
                        streak_d = 4'd0;
                    end
                end else if (step) begin
                    pos_d = pos_q + 4'd1;
                end
            end
            StHit, StMiss: begin
                if (step) begin
                    if (tmr_q == HOLD_LAST) begin
                        tmr_d   = '0;
                        state_d = StIdle;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        LED = 16'd0;
        unique case (state_q)
            StIdle:        LED = 16'd1 << TGT;
            StRun, StMiss: LED = 16'd1 << pos_q;
            StHit:         LED = 16'hFFFF;
            default:       LED = 16'd1 << TGT;
        endcase
    end

    assign STATE  = state_q;
    assign SCORE  = score_q;
    assign STREAK = streak_q;
    assign WIN    = win_q;
    assign LOSE   = lose_q;

endmodule

// File: tb/tb_precision_game_core.sv
// Directed bench for precision_game_core: it covers reset, hit, miss, wrap, hold timing,
// coincident press/step, saturation, reset aborting a run, and a button held through reset.
module tb_precision_game_core;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MODE;
    logic        BTN;
    logic [15:0] LED;
    logic [1:0]  STATE;
    logic [7:0]  SCORE;
    logic [3:0]  STREAK;
    logic        WIN;
    logic        LOSE;

    int n_cmp = 0;
    int n_err = 0;
    int win_cnt = 0;
    int lose_cnt = 0;
    int win_ref, lose_ref;

    precision_game_core #(.TARGET(8), .HOLD_TICKS(8)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .MODE   (MODE),
        .BTN    (BTN),
        .LED    (LED),
        .STATE  (STATE),
        .SCORE  (SCORE),
        .STREAK (STREAK),
        .WIN    (WIN),
        .LOSE   (LOSE)
    );

    always #5 CLK = ~CLK;

    // Count the cycles in which each pulse is high, so that a delta of 1 means exactly one cycle.
    always @(negedge CLK) begin
        if (WIN)  win_cnt++;
        if (LOSE) lose_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Each input event is held for two cycles and then dropped for two, starting from a negedge.
    task automatic mode_edge();
        MODE = 1'b1;
        repeat (2) @(negedge CLK);
        MODE = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic btn_press();
        BTN = 1'b1;
        repeat (2) @(negedge CLK);
        BTN = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic both_edge();
        MODE = 1'b1;
        BTN  = 1'b1;
        repeat (2) @(negedge CLK);
        MODE = 1'b0;
        BTN  = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic snap();
        win_ref  = win_cnt;
        lose_ref = lose_cnt;
    endtask

    initial begin
        RST  = 1'b1;
        MODE = 1'b0;
        BTN  = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("rst_state",  32'(STATE),  32'd0);
        check_eq("rst_led",    32'(LED),    32'h0100);
        check_eq("rst_score",  32'(SCORE),  32'd0);
        check_eq("rst_streak", 32'(STREAK), 32'd0);
        check_eq("rst_win",    32'(WIN),    32'd0);
        check_eq("rst_lose",   32'(LOSE),   32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Basic hit
        snap();
        btn_press();
        check_eq("start_state", 32'(STATE), 32'd1);
        check_eq("start_led",   32'(LED),   32'h0001);
        repeat (8) mode_edge();
        check_eq("run8_led", 32'(LED), 32'h0100);
        btn_press();
        check_eq("hit_state",  32'(STATE),           32'd2);
        check_eq("hit_win",    32'(win_cnt - win_ref),   32'd1);
        check_eq("hit_lose",   32'(lose_cnt - lose_ref), 32'd0);
        check_eq("hit_score",  32'(SCORE),           32'd1);
        check_eq("hit_streak", 32'(STREAK),          32'd1);
        check_eq("hit_led",    32'(LED),             32'hFFFF);

        // The hold lasts 8 steps, and a press during the hold is ignored
        for (int i = 0; i < 8; i++) begin
            mode_edge();
            if (i == 2) btn_press();
            if (i == 6) check_eq("hold7_state", 32'(STATE), 32'd2);
        end
        check_eq("hold_done_state", 32'(STATE), 32'd0);
        check_eq("hold_done_score", 32'(SCORE), 32'd1);
        check_eq("hold_done_led",   32'(LED),   32'h0100);

        // Miss at position 5
        snap();
        btn_press();
        repeat (5) mode_edge();
        btn_press();
        check_eq("miss_state",  32'(STATE),           32'd3);
        check_eq("miss_lose",   32'(lose_cnt - lose_ref), 32'd1);
        check_eq("miss_win",    32'(win_cnt - win_ref),   32'd0);
        check_eq("miss_led",    32'(LED),             32'h0020);
        check_eq("miss_streak", 32'(STREAK),          32'd0);
        check_eq("miss_score",  32'(SCORE),           32'd1);
        repeat (3) mode_edge();
        check_eq("miss_frozen_led", 32'(LED), 32'h0020);
        repeat (5) mode_edge();
        check_eq("miss_done_state", 32'(STATE), 32'd0);

        // Position wraps after 20 steps, then a press coincides with a step at position 8
        btn_press();
        repeat (20) mode_edge();
        check_eq("wrap_led",   32'(LED),   32'h0010);
        check_eq("wrap_state", 32'(STATE), 32'd1);
        repeat (4) mode_edge();
        check_eq("pos8_led", 32'(LED), 32'h0100);
        snap();
        both_edge();
        check_eq("coinc_state",  32'(STATE),         32'd2);
        check_eq("coinc_pos",    32'(dut.pos_q),     32'd8);
        check_eq("coinc_win",    32'(win_cnt - win_ref), 32'd1);
        check_eq("coinc_score",  32'(SCORE),         32'd2);
        check_eq("coinc_streak", 32'(STREAK),        32'd1);
        repeat (8) mode_edge();
        check_eq("coinc_idle", 32'(STATE), 32'd0);

        // 253 more hits bring the score to 255 and saturate the streak
        for (int h = 0; h < 253; h++) begin
            btn_press();
            repeat (8) mode_edge();
            btn_press();
            repeat (8) mode_edge();
        end
        check_eq("pre_sat_score",  32'(SCORE),  32'd255);
        check_eq("pre_sat_streak", 32'(STREAK), 32'd15);
        snap();
        btn_press();
        repeat (8) mode_edge();
        btn_press();
        check_eq("sat_state",  32'(STATE),         32'd2);
        check_eq("sat_win",    32'(win_cnt - win_ref), 32'd1);
        check_eq("sat_score",  32'(SCORE),         32'd255);
        check_eq("sat_streak", 32'(STREAK),        32'd15);
        repeat (8) mode_edge();

        // Reset mid-run with a press in flight, with BTN held high through reset release
        btn_press();
        repeat (3) mode_edge();
        check_eq("pre_rst_led", 32'(LED), 32'h0008);
        snap();
        BTN = 1'b1;
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check_eq("arst_state",  32'(STATE),     32'd0);
        check_eq("arst_led",    32'(LED),       32'h0100);
        check_eq("arst_score",  32'(SCORE),     32'd0);
        check_eq("arst_streak", 32'(STREAK),    32'd0);
        check_eq("arst_pos",    32'(dut.pos_q), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        check_eq("held_btn_state", 32'(STATE), 32'd1);
        check_eq("held_btn_led",   32'(LED),   32'h0001);
        repeat (6) @(negedge CLK);
        BTN = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("held_btn_once", 32'(STATE),           32'd1);
        check_eq("arst_no_win",   32'(win_cnt - win_ref),   32'd0);
        check_eq("arst_no_lose",  32'(lose_cnt - lose_ref), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/precision_game_core.md
PRECISION_GAME_CORE -- requirements
Module: precision_game_core

Interface
REQ-001 Parameter TARGET, default 8, is the winning LED position (0-15).
REQ-002 Parameter HOLD_TICKS, default 8, is the number of step ticks the HIT/MISS result is displayed.
REQ-003 Port CLK, input, 1 bit: system clock; all logic is on the rising edge.
REQ-004 Port RST, input, 1 bit: reset; asynchronous and active-high.
REQ-005 Port MODE, input, 1 bit: game-rate square wave from the difficulty selector; asynchronous to CLK, and is NOT used as a clock.
REQ-006 Port BTN, input, 1 bit: player button, asynchronous, active-high.
REQ-007 Port LED, output, 16 bits: one-hot playfield display.
REQ-008 Port STATE, output, 2 bits: current FSM state code.
REQ-009 Port SCORE, output, 8 bits: total hits.
REQ-010 Port STREAK, output, 4 bits: consecutive hits.
REQ-011 Port WIN, output, 1 bit: one-CLK pulse on a hit.
REQ-012 Port LOSE, output, 1 bit: one-CLK pulse on a miss.

Function
REQ-013 MODE and BTN shall each pass through a 2-flop synchronizer, followed by a registered rising-edge detector that produces internal pulses STEP and PRESS, each one CLK wide.
REQ-014 A rising input level that is stable across edges k and k+1 shall produce a pulse during the cycle after edge k+1; the state effect is visible after edge k+2 (3-edge latency).
REQ-015 The FSM states and STATE encodings shall be IDLE=00, RUN=01, HIT=10, MISS=11.
REQ-016 IDLE: LED shall equal one-hot(TARGET); a PRESS loads POS=0 and moves the FSM to RUN; STEP is ignored.
REQ-017 RUN: LED shall equal one-hot(POS); each STEP increments POS; POS shall wrap from 15 to 0.
REQ-018 RUN with PRESS and POS==TARGET: go to HIT, pulse WIN, SCORE+1 saturating at 255, STREAK+1 saturating at 15.
REQ-019 RUN with PRESS and POS!=TARGET: go to MISS, pulse LOSE, clear STREAK to 0, leave SCORE unchanged.
REQ-020 When PRESS and STEP occur in the same RUN cycle, the comparison shall use POS before the increment, and POS shall not advance.
REQ-021 HIT: LED shall be all ones. MISS: LED shall equal one-hot(POS at the press), frozen.
REQ-022 On entry to HIT or MISS, TMR shall clear; each STEP increments TMR; when TMR reaches HOLD_TICKS the FSM goes to IDLE.
REQ-023 PRESS shall be ignored in HIT and MISS.
REQ-024 WIN and LOSE shall be registered and asserted for exactly one CLK, in the same cycle that STATE changes.
REQ-025 A button held high shall generate exactly one PRESS.
REQ-026 SCORE and STREAK shall change only on the HIT and MISS transitions.

Reset
REQ-027 RST high shall immediately and asynchronously force: STATE=IDLE, POS=0, TMR=0, SCORE=0, STREAK=0, WIN=0, LOSE=0, all synchronizer and edge flops to 0, and LED=one-hot(TARGET).
REQ-028 RST asserted mid-RUN or mid-HIT shall abort the operation with no WIN or LOSE pulse.
REQ-029 After RST deasserts, a MODE or BTN input already high shall produce one STEP or PRESS pulse, not zero pulses and not a stuck-high pulse.

Verification
REQ-030 Reset, then BTN pulse, then 8 MODE rising edges, then BTN pulse -> STATE 01 then 10, WIN one cycle, SCORE=1, STREAK=1, LED=16'hFFFF.
REQ-031 Start, 5 MODE edges, BTN pulse -> STATE=11, LOSE one cycle, LED=16'h0020, STREAK=0, SCORE unchanged.
REQ-032 Start, 20 MODE edges -> POS=4 (wrap verified), LED=16'h0010.
REQ-033 HIT, then 8 MODE edges with a BTN press at edge 3 -> STATE returns to 00 after the 8th STEP, and the press has no effect.
REQ-034 PRESS and STEP coincident with POS=8 -> HIT, and POS stays 8.
REQ-035 Preload SCORE=255 and STREAK=15 via 255 hits, then one more hit -> both saturate; RST mid-RUN -> all outputs at reset values, with no WIN or LOSE pulse.
